// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter (dmem_arbiter, dmem_arb_grant).
package dmem_pkg;

    localparam int DMEM_WORDS = 32;
    localparam int DMEM_AW    = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e             owner;
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [XLEN-1:0]    wdata;
    } iss_entry_t;

    // Byte address to RAM word index; the low byte-offset bits are dropped.
    function automatic logic [DMEM_AW-1:0] word_addr(input logic [6:0] byte_addr);
        return byte_addr[6:2];
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant plus owner/starvation state for dmem_arbiter.
// Define DMEM_ARB_RR_EN for round-robin contention resolution; default is core priority.
module dmem_arb_grant
    import dmem_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_valid,
    input  logic       host_valid,
    input  logic       host_lock,
    output logic       core_grant,
    output logic       host_grant,
    output logic [1:0] owner
);

    localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    logic          lock_hold;
    logic          core_wins;

    always_comb begin
        expired   = (cnt_q == CNT_MAX);
        lock_hold = (owner_q == OWN_HOST) && host_lock && host_valid && !expired;
`ifdef DMEM_ARB_RR_EN
        // On contention the side that did not win last cycle goes first; IDLE favours the core.
        core_wins = core_valid && (!host_valid || (owner_q != OWN_CORE));
`else
        core_wins = core_valid;
`endif
        core_grant = 1'b0;
        host_grant = 1'b0;
        if (!rst) begin
            core_grant = 1'b0;
            host_grant = 1'b0;
        end else if (core_valid && expired) begin
            core_grant = 1'b1;
        end else if (lock_hold) begin
            host_grant = 1'b1;
        end else if (core_wins) begin
            core_grant = 1'b1;
        end else begin
            host_grant = host_valid;
        end
    end

    always_comb begin
        owner_d = OWN_IDLE;
        if (core_grant) begin
            owner_d = OWN_CORE;
        end else if (host_grant) begin
            owner_d = OWN_HOST;
        end

        // Counts host wins while the core is waiting; any core win or idle core clears it.
        cnt_d = cnt_q;
        if (!core_valid || core_grant) begin
            cnt_d = '0;
        end else if (host_grant && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IDLE;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner = owner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter in front of the 32-word data RAM: grant, issue register, response stage.
// Define DMEM_ARB_RR_EN to replace core priority with round-robin on contention.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_valid,
    output logic        core_ready,
    input  logic        core_we,
    input  logic [6:0]  core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_rsp,
    output logic [31:0] core_rdata,
    output logic        core_stall,

    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_rsp,
    output logic [31:0] host_rdata,
    input  logic        host_lock,

    output logic        mem_en,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  owner_dbg
);

    logic       core_grant;
    logic       host_grant;

    iss_entry_t iss_q, iss_d;
    logic       iss_vld_q, iss_vld_d;
    owner_e     rsp_own_q, rsp_own_d;
    logic       rsp_vld_q, rsp_vld_d;
    logic       rsp_we_q, rsp_we_d;
    logic       unused_addr_bits;

    dmem_arb_grant #(
        .HOLD_MAX(HOLD_MAX)
    ) u_grant (
        .clk        (clk),
        .rst        (rst),
        .core_valid (core_valid),
        .host_valid (host_valid),
        .host_lock  (host_lock),
        .core_grant (core_grant),
        .host_grant (host_grant),
        .owner      (owner_dbg)
    );

    // Idle issue slots are zeroed so mem_addr/mem_wdata stay quiet between accesses.
    always_comb begin
        iss_vld_d = core_grant | host_grant;
        iss_d     = '0;
        if (core_grant) begin
            iss_d.owner = OWN_CORE;
            iss_d.we    = core_we;
            iss_d.addr  = word_addr(core_addr);
            iss_d.wdata = core_wdata;
        end else if (host_grant) begin
            iss_d.owner = OWN_HOST;
            iss_d.we    = host_we;
            iss_d.addr  = word_addr(host_addr);
            iss_d.wdata = host_wdata;
        end

        rsp_vld_d = iss_vld_q;
        rsp_own_d = iss_q.owner;
        rsp_we_d  = iss_q.we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q     <= '0;
            iss_vld_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_own_q <= OWN_IDLE;
            rsp_we_q  <= 1'b0;
        end else begin
            iss_q     <= iss_d;
            iss_vld_q <= iss_vld_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
            rsp_we_q  <= rsp_we_d;
        end
    end

    assign core_ready = core_grant;
    assign host_ready = host_grant;
    assign core_stall = core_valid & ~core_grant;

    assign mem_en    = iss_vld_q;
    assign mem_we    = iss_vld_q & iss_q.we;
    assign mem_addr  = iss_q.addr;
    assign mem_wdata = iss_q.wdata;

    // RAM output is registered, so it lines up with the response stage.
    assign core_rsp   = rsp_vld_q && (rsp_own_q == OWN_CORE);
    assign host_rsp   = rsp_vld_q && (rsp_own_q == OWN_HOST);
    assign core_rdata = (core_rsp && !rsp_we_q) ? mem_rdata : '0;
    assign host_rdata = (host_rsp && !rsp_we_q) ? mem_rdata : '0;

    assign unused_addr_bits = ^{core_addr[1:0], host_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int HOLD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_ready, core_we, core_rsp, core_stall;
    logic [6:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        host_valid, host_ready, host_we, host_rsp, host_lock;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  owner_dbg;

    always #5 clk = ~clk;

    dmem_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rsp(core_rsp),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rsp(host_rsp),
        .host_rdata(host_rdata), .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner_dbg(owner_dbg)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i * 3 + 1);
    endfunction

    // Single-port RAM environment: registered read, write on mem_we.
    logic [31:0] ram [32];
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Model: arbitration rules over last winner and waiting count; transactions in two queues.
    typedef struct {
        bit          host;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        mem_q[$];
    txn_t        exp_q[$];
    txn_t        t;
    int          m_last = 0;
    int          m_cnt  = 0;
    logic [31:0] gold [32];
    bit          gold_init = 1'b0;
    bit          gc, gh;

    function automatic void model_grant(output bit c, output bit h);
        c = 1'b0;
        h = 1'b0;
        if (core_valid && m_cnt >= HOLD_MAX) c = 1'b1;
        else if (m_last == 2 && host_lock && host_valid) h = 1'b1;
        else if (core_valid && host_valid) begin
`ifdef DMEM_ARB_RR_EN
            c = (m_last != 1);
            h = !c;
`else
            c = 1'b1;
`endif
        end else begin
            c = core_valid;
            h = host_valid;
        end
    endfunction

    always @(negedge clk) begin
        if (!gold_init) begin
            for (int i = 0; i < 32; i++) gold[i] = init_word(i);
            gold_init = 1'b1;
        end
        if (!rst) begin
            chk1("rst_core_ready", core_ready, 1'b0);
            chk1("rst_host_ready", host_ready, 1'b0);
            chk1("rst_core_rsp", core_rsp, 1'b0);
            chk1("rst_host_rsp", host_rsp, 1'b0);
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk32("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk32("rst_mem_wdata", mem_wdata, 32'd0);
            chk32("rst_core_rdata", core_rdata, 32'd0);
            chk32("rst_host_rdata", host_rdata, 32'd0);
            chk1("rst_stall", core_stall, core_valid);
            chk32("rst_owner", 32'(owner_dbg), 32'd0);
            mem_q.delete();
            exp_q.delete();
            m_last = 0;
            m_cnt  = 0;
        end else begin
            chk32("owner", 32'(owner_dbg), 32'(m_last));
            model_grant(gc, gh);
            chk1("core_ready", core_ready, gc);
            chk1("host_ready", host_ready, gh);
            chk1("core_stall", core_stall, core_valid & ~gc);

            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                chk1("core_rsp", core_rsp, !t.host);
                chk1("host_rsp", host_rsp, t.host);
                chk32("core_rdata", core_rdata, (!t.host && !t.we) ? t.rdata : 32'd0);
                chk32("host_rdata", host_rdata, (t.host && !t.we) ? t.rdata : 32'd0);
            end else begin
                chk1("core_rsp_idle", core_rsp, 1'b0);
                chk1("host_rsp_idle", host_rsp, 1'b0);
                chk32("core_rdata_idle", core_rdata, 32'd0);
                chk32("host_rdata_idle", host_rdata, 32'd0);
            end

            if (mem_q.size() > 0) begin
                t = mem_q.pop_front();
                chk1("mem_en", mem_en, 1'b1);
                chk1("mem_we", mem_we, t.we);
                chk32("mem_addr", 32'(mem_addr), 32'(t.addr));
                if (t.we) begin
                    chk32("mem_wdata", mem_wdata, t.wdata);
                    gold[t.addr] = t.wdata;
                end else begin
                    t.rdata = gold[t.addr];
                end
                exp_q.push_back(t);
            end else begin
                chk1("mem_en_idle", mem_en, 1'b0);
                chk1("mem_we_idle", mem_we, 1'b0);
            end

            if (gc || gh) begin
                t.host  = gh;
                t.we    = gh ? host_we : core_we;
                t.addr  = gh ? host_addr[6:2] : core_addr[6:2];
                t.wdata = gh ? host_wdata : core_wdata;
                t.rdata = '0;
                mem_q.push_back(t);
            end
            if (!core_valid || gc) m_cnt = 0;
            else if (gh && m_cnt < HOLD_MAX) m_cnt = m_cnt + 1;
            m_last = gc ? 1 : (gh ? 2 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        core_valid = 1'b0;
        host_valid = 1'b0;
        host_lock  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] pat;
    int         acc, n_rsp, n_we;

    initial begin
        rst = 1'b0;
        core_valid = 1'b1; core_we = 1'b0; core_addr = 7'h10; core_wdata = '0;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 7'h04; host_wdata = '0;
        host_lock  = 1'b0;

        // Reset with both requesters active, then the first core request is taken at release.
        repeat (3) begin
            @(negedge clk);
            chk1("lit_rst_core_ready", core_ready, 1'b0);
            chk1("lit_rst_mem_en", mem_en, 1'b0);
            chk1("lit_rst_stall", core_stall, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("lit_rel_core_ready", core_ready, 1'b1);
        chk1("lit_rel_host_ready", host_ready, 1'b0);
        tick();
        idle(2);

        // Store then load back-to-back at byte address 0x14 (word 5).
        core_valid = 1'b1; core_we = 1'b1; core_addr = 7'h14; core_wdata = 32'hDEADBEEF;
        @(negedge clk); chk1("lit_st_acc", core_ready, 1'b1);
        tick();
        core_we = 1'b0; core_wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk1("lit_st_mem_we", mem_we, 1'b1);
        chk32("lit_st_mem_addr", 32'(mem_addr), 32'd5);
        chk32("lit_st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        core_valid = 1'b0; core_addr = 7'h55;
        @(negedge clk);
        chk1("lit_st_rsp", core_rsp, 1'b1);
        chk32("lit_st_rdata", core_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk1("lit_ld_rsp", core_rsp, 1'b1);
        chk32("lit_ld_rdata", core_rdata, 32'hDEADBEEF);
        tick();
        idle(2);

        // Contention without lock: core first, host once the core drops.
        core_valid = 1'b1; core_we = 1'b0; core_addr = 7'h08;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 7'h0C; host_lock = 1'b0;
        @(negedge clk);
        chk1("lit_cont_core_ready", core_ready, 1'b1);
        chk1("lit_cont_host_ready", host_ready, 1'b0);
        chk1("lit_cont_stall", core_stall, 1'b0);
        tick();
        core_valid = 1'b0;
        @(negedge clk); chk1("lit_cont_host_grant", host_ready, 1'b1);
        tick();
        idle(2);

        // Locked host burst against a waiting core: H H H H C H.
        host_valid = 1'b1; host_lock = 1'b1; host_we = 1'b0; host_addr = 7'h40;
        tick();
        core_valid = 1'b1; core_we = 1'b0; core_addr = 7'h18;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            bit cr;
            @(negedge clk);
            if (i == 0) chk1("lit_lock_stall", core_stall, 1'b1);
            pat[5-i] = host_ready;
            cr = core_ready;
            tick();
            host_addr = 7'(7'h40 + 7'(4 * (i + 1)));
            if (cr) core_valid = 1'b0;
        end
        chk32("lit_lock_pattern", 32'(pat), 32'(6'b111101));
        idle(3);

        // Back-to-back host loads of words 0..7 with random byte-offset bits.
        acc = 0; n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            host_valid = 1'b1; host_we = 1'b0;
            host_addr = {5'(i), 2'($urandom_range(0, 3))};
            @(negedge clk);
            if (host_ready) acc++;
            if (host_rsp) n_rsp++;
            if (i == 7) chk32("lit_b2b_word5", host_rdata, 32'hDEADBEEF);
            tick();
        end
        host_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (host_rsp) n_rsp++;
            tick();
        end
        chk32("lit_b2b_accepts", 32'(acc), 32'd8);
        chk32("lit_b2b_rsps", 32'(n_rsp), 32'd8);
        idle(1);

        // Address wrap: 0x7F and 0x7C both select word 31.
        core_valid = 1'b1; core_we = 1'b1; core_addr = 7'h7F; core_wdata = 32'hCAFEF00D;
        tick();
        core_valid = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 7'h7C;
        tick();
        host_valid = 1'b0;
        tick();
        @(negedge clk);
        chk1("lit_wrap_rsp", host_rsp, 1'b1);
        chk32("lit_wrap_rdata", host_rdata, 32'hCAFEF00D);
        tick();
        idle(2);

        // Reset one cycle after a store is accepted: the store must vanish.
        core_valid = 1'b1; core_we = 1'b1; core_addr = 7'h20; core_wdata = 32'h12345678;
        tick();
        core_valid = 1'b0; rst = 1'b0;
        n_we = 0; n_rsp = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_we) n_we++;
            if (core_rsp) n_rsp++;
            tick();
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_we) n_we++;
            if (core_rsp) n_rsp++;
            tick();
        end
        chk32("lit_rmid_mem_we", 32'(n_we), 32'd0);
        chk32("lit_rmid_core_rsp", 32'(n_rsp), 32'd0);
        chk32("lit_rmid_ram", ram[8], init_word(8));
        idle(1);

        // Continuous contention from IDLE.
        core_valid = 1'b1; core_we = 1'b0; core_addr = 7'h30;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 7'h34; host_lock = 1'b0;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[5-i] = host_ready;
            tick();
        end
`ifdef DMEM_ARB_RR_EN
        chk32("lit_contention_pattern", 32'(pat), 32'(6'b010101));
`else
        chk32("lit_contention_pattern", 32'(pat), 32'(6'b000000));
`endif
        idle(2);

        // Mixed traffic; the model checks every cycle.
        for (int i = 0; i < 300; i++) begin
            core_valid = 1'($urandom_range(0, 1));
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 7'($urandom_range(0, 127));
            core_wdata = $urandom;
            host_valid = 1'($urandom_range(0, 3) != 0);
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 7'($urandom_range(0, 127));
            host_wdata = $urandom;
            host_lock  = 1'($urandom_range(0, 1));
            tick();
        end
        idle(4);

        for (int i = 0; i < 32; i++) chk32("ram_final", ram[i], gold[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
